// File: rtl/mdu_maindec.sv
// mdu_maindec: decode-stage main decoder with a HI/LO multiply/divide sequencer.
// Produces the combinational control bundle for I-, J- and R-type instructions.
// It tracks one in-flight MDU operation and stalls dependent HI/LO users until
// the result has been written.
// Optional feature: define MDU_DIV_EN to enable DIV/DIVU sequencing.
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_valid, i_op[5:0], i_func[5:0]                      decode-stage instruction
//   o_regwrite, o_memtoreg, o_memwrite, o_memread        datapath controls
//   o_regdst[1:0], o_outselect[1:0], o_alu_src, o_alu_mid[2:0], o_se_ze
//   o_beq, o_bne, o_jump                                 control flow
//   o_md_start, o_md_signed, o_md_div                    MDU launch
//   o_md_busy, o_md_done, o_stall                        sequencer status / hazard
module mdu_maindec #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic       o_regwrite,
  output logic       o_memtoreg,
  output logic       o_memwrite,
  output logic       o_memread,
  output logic [1:0] o_regdst,
  output logic [1:0] o_outselect,
  output logic       o_alu_src,
  output logic [2:0] o_alu_mid,
  output logic       o_se_ze,
  output logic       o_beq,
  output logic       o_bne,
  output logic       o_jump,
  output logic       o_md_start,
  output logic       o_md_signed,
  output logic       o_md_div,
  output logic       o_md_busy,
  output logic       o_md_done,
  output logic       o_stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_regwrite, w_memtoreg, w_memwrite, w_memread;
  logic [1:0] w_regdst, w_outselect;
  logic       w_alu_src, w_se_ze, w_beq, w_bne, w_jump;
  logic [2:0] w_alu_mid;
  logic       w_md_signed, w_is_mdop, w_is_div, w_hilo;
  logic       w_active, w_busy, w_stall;

  // Raw opcode/function decode, before valid/stall gating.
  always_comb begin
    w_regwrite  = 1'b0;
    w_memtoreg  = 1'b0;
    w_memwrite  = 1'b0;
    w_memread   = 1'b0;
    w_regdst    = 2'b00;
    w_outselect = 2'b00;
    w_alu_src   = 1'b0;
    w_alu_mid   = 3'b000;
    w_se_ze     = 1'b0;
    w_beq       = 1'b0;
    w_bne       = 1'b0;
    w_jump      = 1'b0;
    w_md_signed = 1'b0;
    w_is_mdop   = 1'b0;
    w_is_div    = 1'b0;
    w_hilo      = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_MFHI: begin
            w_regwrite = 1'b1; w_regdst = 2'b01; w_outselect = 2'b11; w_hilo = 1'b1;
          end
          FN_MFLO: begin
            w_regwrite = 1'b1; w_regdst = 2'b01; w_outselect = 2'b10; w_hilo = 1'b1;
          end
          FN_MULT:  begin w_md_signed = 1'b1; w_is_mdop = 1'b1; w_hilo = 1'b1; end
          FN_MULTU: begin w_is_mdop = 1'b1; w_hilo = 1'b1; end
`ifdef MDU_DIV_EN
          FN_DIV:  begin w_md_signed = 1'b1; w_is_mdop = 1'b1; w_is_div = 1'b1; w_hilo = 1'b1; end
          FN_DIVU: begin w_is_mdop = 1'b1; w_is_div = 1'b1; w_hilo = 1'b1; end
`else
          // Divide not built: DIV/DIVU behave as NOPs.
          FN_DIV, FN_DIVU: begin end
`endif
          default: begin
            w_regwrite = 1'b1; w_regdst = 2'b01; w_alu_mid = 3'b111;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_regwrite = 1'b1; w_alu_src = 1'b1; w_se_ze = 1'b1; w_alu_mid = 3'b000;
      end
      OP_SLTI, OP_SLTIU: begin
        w_regwrite = 1'b1; w_alu_src = 1'b1; w_se_ze = 1'b1; w_alu_mid = 3'b101;
      end
      OP_ANDI: begin w_regwrite = 1'b1; w_alu_src = 1'b1; w_alu_mid = 3'b010; end
      OP_ORI:  begin w_regwrite = 1'b1; w_alu_src = 1'b1; w_alu_mid = 3'b011; end
      OP_XORI: begin w_regwrite = 1'b1; w_alu_src = 1'b1; w_alu_mid = 3'b100; end
      OP_LUI:  begin w_regwrite = 1'b1; w_outselect = 2'b01; end
      OP_LW: begin
        w_regwrite = 1'b1; w_memtoreg = 1'b1; w_memread = 1'b1;
        w_alu_src = 1'b1; w_se_ze = 1'b1;
      end
      OP_SW:  begin w_memwrite = 1'b1; w_alu_src = 1'b1; w_se_ze = 1'b1; end
      OP_BEQ: w_beq  = 1'b1;
      OP_BNE: w_bne  = 1'b1;
      OP_J:   w_jump = 1'b1;
      default: begin end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output gating and sequencer next state. Reset also blanks the decode
  // outputs so the asynchronous reset is visible immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_active    = i_valid & ~i_reset;
    w_busy      = (r_state == S_BUSY);
    w_stall     = w_active & w_hilo & w_busy;

    o_stall     = w_stall;
    o_md_busy   = w_busy;
    o_md_done   = w_busy & (r_cnt == '0);
    o_md_start  = (r_state == S_IDLE) & w_active & w_is_mdop & ~w_stall;

    // Stalled bubble: suppress every architectural side effect.
    o_regwrite  = w_active & w_regwrite & ~w_stall;
    o_memwrite  = w_active & w_memwrite & ~w_stall;
    o_memread   = w_active & w_memread  & ~w_stall;
    o_beq       = w_active & w_beq      & ~w_stall;
    o_bne       = w_active & w_bne      & ~w_stall;
    o_jump      = w_active & w_jump     & ~w_stall;
    o_memtoreg  = w_active & w_memtoreg;
    o_regdst    = w_active ? w_regdst    : 2'b00;
    o_outselect = w_active ? w_outselect : 2'b00;
    o_alu_src   = w_active & w_alu_src;
    o_alu_mid   = w_active ? w_alu_mid   : 3'b000;
    o_se_ze     = w_active & w_se_ze;
    o_md_signed = w_active & w_md_signed;
    o_md_div    = w_active & w_is_div;

    case (r_state)
      S_IDLE: begin
        if (o_md_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_maindec.sv
module tb_mdu_maindec;

  localparam int unsigned MULC = 4;
  localparam int unsigned DIVC = 32;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic [1:0] regdst;
    logic [1:0] outselect;
    logic       alu_src;
    logic [2:0] alu_mid;
    logic       se_ze;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       md_signed;
    logic       md_div;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] func = 6'h00;
  logic       regwrite, memtoreg, memwrite, memread;
  logic [1:0] regdst, outselect;
  logic       alu_src, se_ze, beq, bne, jump;
  logic [2:0] alu_mid;
  logic       md_start, md_signed, md_div, md_busy, md_done, stall;

  int tests = 0;
  int fails = 0;

  // Reference model: the cycle the last operation launched and its latency.
  int cyc = 0;
  int start_cyc = -1;
  int lat = 0;

  mdu_maindec #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_op(op), .i_func(func),
    .o_regwrite(regwrite), .o_memtoreg(memtoreg), .o_memwrite(memwrite),
    .o_memread(memread), .o_regdst(regdst), .o_outselect(outselect),
    .o_alu_src(alu_src), .o_alu_mid(alu_mid), .o_se_ze(se_ze),
    .o_beq(beq), .o_bne(bne), .o_jump(jump),
    .o_md_start(md_start), .o_md_signed(md_signed), .o_md_div(md_div),
    .o_md_busy(md_busy), .o_md_done(md_done), .o_stall(stall)
  );

  always #5 clk = ~clk;

`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  function automatic bit is_mdop(input logic [5:0] o, input logic [5:0] f);
    if (o != 6'h00) return 1'b0;
    if (f == 6'h18 || f == 6'h19) return 1'b1;
    if (DIV_ON && (f == 6'h1A || f == 6'h1B)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_hilo(input logic [5:0] o, input logic [5:0] f);
    return is_mdop(o, f) || (o == 6'h00 && (f == 6'h10 || f == 6'h12));
  endfunction

  // Ungated per-instruction controls, straight from the instruction table.
  function automatic ctrl_t ref_decode(input logic [5:0] o, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (o)
      6'h00: begin
        if (f == 6'h10) begin c.regwrite = 1; c.regdst = 2'b01; c.outselect = 2'b11; end
        else if (f == 6'h12) begin c.regwrite = 1; c.regdst = 2'b01; c.outselect = 2'b10; end
        else if (f == 6'h18) c.md_signed = 1;
        else if (f == 6'h19) c = '0;
        else if (f == 6'h1A || f == 6'h1B) begin
          if (DIV_ON) begin c.md_div = 1; c.md_signed = (f == 6'h1A); end
        end else begin c.regwrite = 1; c.regdst = 2'b01; c.alu_mid = 3'b111; end
      end
      6'h08, 6'h09: begin c.regwrite = 1; c.alu_src = 1; c.se_ze = 1; end
      6'h0A, 6'h0B: begin c.regwrite = 1; c.alu_src = 1; c.se_ze = 1; c.alu_mid = 3'b101; end
      6'h0C: begin c.regwrite = 1; c.alu_src = 1; c.alu_mid = 3'b010; end
      6'h0D: begin c.regwrite = 1; c.alu_src = 1; c.alu_mid = 3'b011; end
      6'h0E: begin c.regwrite = 1; c.alu_src = 1; c.alu_mid = 3'b100; end
      6'h0F: begin c.regwrite = 1; c.outselect = 2'b01; end
      6'h23: begin c.regwrite = 1; c.memtoreg = 1; c.memread = 1; c.alu_src = 1; c.se_ze = 1; end
      6'h2B: begin c.memwrite = 1; c.alu_src = 1; c.se_ze = 1; end
      6'h04: c.beq = 1;
      6'h05: c.bne = 1;
      6'h02: c.jump = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One cycle: drive at the falling edge, check mid-cycle, update model at the rising edge.
  task automatic step(input logic v, input logic [5:0] o, input logic [5:0] f, input logic r);
    ctrl_t exp_c, obs_c;
    bit    busy, exp_stall, exp_start, exp_done;
    @(negedge clk);
    valid = v; op = o; func = f; reset = r;
    #1;
    if (r) start_cyc = -1;
    busy      = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + int'(lat));
    exp_done  = busy && (cyc == start_cyc + int'(lat));
    exp_stall = v && !r && busy && is_hilo(o, f);
    exp_start = v && !r && !busy && is_mdop(o, f);
    exp_c     = (v && !r) ? ref_decode(o, f) : '0;
    if (exp_stall) begin
      exp_c.regwrite = 0; exp_c.memwrite = 0; exp_c.memread = 0;
      exp_c.beq = 0; exp_c.bne = 0; exp_c.jump = 0;
    end
    obs_c = '{regwrite, memtoreg, memwrite, memread, regdst, outselect, alu_src,
              alu_mid, se_ze, beq, bne, jump, md_signed, md_div};
    tests++;
    assert (obs_c === exp_c) else begin
      fails++; $error("FAIL ctrl cyc=%0d op=%h func=%h obs=%h exp=%h", cyc, o, f, obs_c, exp_c);
    end
    tests++;
    assert (stall === exp_stall) else begin
      fails++; $error("FAIL stall cyc=%0d obs=%b exp=%b", cyc, stall, exp_stall);
    end
    tests++;
    assert (md_start === exp_start) else begin
      fails++; $error("FAIL md_start cyc=%0d obs=%b exp=%b", cyc, md_start, exp_start);
    end
    tests++;
    assert (md_busy === busy) else begin
      fails++; $error("FAIL md_busy cyc=%0d obs=%b exp=%b", cyc, md_busy, busy);
    end
    tests++;
    assert (md_done === exp_done) else begin
      fails++; $error("FAIL md_done cyc=%0d obs=%b exp=%b", cyc, md_done, exp_done);
    end
    @(posedge clk);
    if (exp_start) begin
      start_cyc = cyc;
      lat = (o == 6'h00 && (f == 6'h1A || f == 6'h1B)) ? DIVC : MULC;
    end
    cyc++;
  endtask

  initial begin
    logic [5:0] ops [15];
    logic [5:0] fns [8];
    logic [5:0] ro, rf;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h2A};

    // Reset, then ADDI / SW.
    step(1'b0, 6'h00, 6'h00, 1'b1);
    step(1'b1, 6'h00, 6'h20, 1'b1);
    step(1'b1, 6'h08, 6'h00, 1'b0);
    step(1'b1, 6'h2B, 6'h00, 1'b0);
    // MULT alone, idle through its latency.
    step(1'b1, 6'h00, 6'h18, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 6'h00, 6'h00, 1'b0);
    // MULTU, then MFLO held until released.
    step(1'b1, 6'h00, 6'h19, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 6'h00, 6'h12, 1'b0);
    // Back-to-back MULT, plus ADD/branch/LW during BUSY.
    step(1'b1, 6'h00, 6'h18, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 6'h00, 6'h18, 1'b0);
    step(1'b1, 6'h00, 6'h20, 1'b0);
    step(1'b1, 6'h04, 6'h00, 1'b0);
    step(1'b1, 6'h23, 6'h00, 1'b0);
    step(1'b1, 6'h00, 6'h10, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 6'h00, 6'h00, 1'b0);
    // Reset mid-multiply, then MFHI proceeds.
    step(1'b1, 6'h00, 6'h18, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);
    step(1'b1, 6'h00, 6'h10, 1'b1);
    step(1'b1, 6'h00, 6'h10, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'h00, 6'h00, 1'b0);
    // DIVU: sequenced only when divide is built.
    step(1'b1, 6'h00, 6'h1B, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 6'h00, 6'h12, 1'b0);

    // Randomised instruction stream against the model.
    for (int i = 0; i < 1500; i++) begin
      ro = ops[$urandom_range(14, 0)];
      rf = ($urandom_range(3, 0) == 0) ? 6'($urandom) : fns[$urandom_range(7, 0)];
      if (ro == 6'h3F) ro = 6'($urandom);
      step($urandom_range(99, 0) < 85, ro, rf, $urandom_range(79, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
